regfile_bypass_sb: RTL
======================

Name: regfile_bypass_sb

Overview:
- Parametrised successor register file for the RV32IM pipeline (ID stage).
- Generalises width, depth and reset mode.
- Adds hardwired x0, same-cycle write-to-read bypass, and a per-register busy scoreboard with pending counter for hazard detection.
- Decode reads operands and busy flags combinationally; WB stage writes; issue logic marks destination registers pending.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (2..2^AW).
- AW, 5, address width.
- RESET_MODE, 1, 0 = all registers reset to 0; 1 = register i resets to i (truncated to XLEN), except x0 = 0.
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads see stored contents only.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- RS1_ADDR  input  AW  read port 1 address.
- RS2_ADDR  input  AW  read port 2 address.
- RS1_DATA  output  XLEN  read port 1 data (combinational).
- RS2_DATA  output  XLEN  read port 2 data (combinational).
- RS1_BUSY  output  1  RS1_ADDR has an outstanding producer.
- RS2_BUSY  output  1  RS2_ADDR has an outstanding producer.
- WB_EN  input  1  writeback enable.
- WB_ADDR  input  AW  writeback register address.
- WB_DATA  input  XLEN  writeback data.
- ISSUE_EN  input  1  instruction with destination issued this cycle.
- ISSUE_RD  input  AW  destination register of issued instruction.
- FLUSH  input  1  pipeline flush; clears all busy bits.
- PENDING_CNT  output  AW+1  number of set busy bits (registered).

Behaviour:
- Interface: one clock CLK; RESET is synchronous and active-high. Priority: RESET > FLUSH > ISSUE > WB for busy state.
- Reset: on a CLK edge with RESET=1, registers load per RESET_MODE, all busy bits clear, PENDING_CNT=0. WB/ISSUE/FLUSH in that cycle are ignored. Reset mid-operation discards all pending state.
- x0: writes to address 0 are ignored; issue to address 0 never sets busy. Reads of address 0 return 0 with BUSY=0.
- Out-of-range addresses (>= NREGS): reads return 0 with BUSY=0; writes and issues are ignored.
- Write: WB_EN=1 with a valid nonzero WB_ADDR stores WB_DATA at the edge. Contents are visible in the array from the next cycle.
- Read: RSx_DATA = array[RSx_ADDR], zero latency.
- Bypass (BYPASS=1): if WB_EN=1, WB_ADDR==RSx_ADDR and the address is valid and nonzero, RSx_DATA = WB_DATA in the same cycle. Both ports may bypass simultaneously.
- Busy set: ISSUE_EN=1 with valid nonzero ISSUE_RD sets busy[ISSUE_RD] at the edge.
- Busy clear: WB_EN=1 with valid nonzero WB_ADDR clears busy[WB_ADDR] at the edge.
- Same-cycle ISSUE and WB to the same register: set wins (new producer), busy stays 1, and the data is still written.
- Issue to an already-busy register: bit stays 1 and PENDING_CNT is unchanged.
- WB to a non-busy register: data is written, busy is unchanged.
- RSx_BUSY = busy[RSx_ADDR] AND NOT (WB_EN AND WB_ADDR==RSx_ADDR), applied only when BYPASS=1. An ISSUE in the same cycle affects RSx_BUSY only from the next cycle.
- FLUSH=1: all busy bits clear at the edge, overriding a same-cycle ISSUE. A same-cycle WB data write still occurs. PENDING_CNT=0 next cycle.
- PENDING_CNT: registered and equal to popcount(busy) after each edge. Increments or decrements by at most 1 per cycle, except a net-zero cycle (issue new reg + WB other busy reg) and FLUSH. Never exceeds NREGS-1.

Test Plan:
- RESET=1 for one edge with RESET_MODE=1 -> RS1_ADDR=7 reads 7, RS2_ADDR=0 reads 0, PENDING_CNT=0, both BUSY=0.
- WB_EN=1, WB_ADDR=5, WB_DATA=0xDEADBEEF, RS1_ADDR=5, same cycle -> RS1_DATA=0xDEADBEEF (BYPASS=1). With BYPASS=0 the stored value shows until the next cycle, then 0xDEADBEEF.
- WB_EN=1, WB_ADDR=0, WB_DATA=0x1234; ISSUE_RD=0 -> next cycle RS1_ADDR=0 reads 0, BUSY=0, PENDING_CNT unchanged.
- ISSUE_RD=3, then ISSUE_RD=4, then WB_ADDR=3 -> PENDING_CNT 1, 2, 1; RS1_BUSY(addr 3) drops in the WB cycle. Then ISSUE_RD=4 and WB_ADDR=4 in the same cycle -> busy[4] stays 1, data written, PENDING_CNT=1.
- Three registers busy, FLUSH=1 with ISSUE_RD=9 -> next cycle PENDING_CNT=0 and busy[9]=0.
- Busy registers 2 and 6, RESET asserted mid-stream with WB_EN=1 to addr 2 -> next cycle reg2 holds its reset value, all busy=0.

Source files
------------

// File: rtl/regfile_bypass_sb_if.sv
// Purpose: bundles the decode read ports, writeback port, issue port and
// scoreboard status of regfile_bypass_sb into one interface.
// Signals:
//   RS1_ADDR/RS2_ADDR  read addresses (from decode)
//   RS1_DATA/RS2_DATA  read data (combinational, to decode)
//   RS1_BUSY/RS2_BUSY  operand has an outstanding producer
//   WB_EN/WB_ADDR/WB_DATA  writeback port
//   ISSUE_EN/ISSUE_RD  destination marked pending by issue logic
//   FLUSH              clears every busy bit
//   PENDING_CNT        registered count of busy registers
// Modports: master = pipeline side, slave = register file.
interface regfile_bypass_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) ();

  logic [AW-1:0]   RS1_ADDR;
  logic [AW-1:0]   RS2_ADDR;
  logic [XLEN-1:0] RS1_DATA;
  logic [XLEN-1:0] RS2_DATA;
  logic            RS1_BUSY;
  logic            RS2_BUSY;
  logic            WB_EN;
  logic [AW-1:0]   WB_ADDR;
  logic [XLEN-1:0] WB_DATA;
  logic            ISSUE_EN;
  logic [AW-1:0]   ISSUE_RD;
  logic            FLUSH;
  logic [AW:0]     PENDING_CNT;

  modport master (
    output RS1_ADDR, RS2_ADDR,
    output WB_EN, WB_ADDR, WB_DATA,
    output ISSUE_EN, ISSUE_RD, FLUSH,
    input  RS1_DATA, RS2_DATA, RS1_BUSY, RS2_BUSY, PENDING_CNT
  );

  modport slave (
    input  RS1_ADDR, RS2_ADDR,
    input  WB_EN, WB_ADDR, WB_DATA,
    input  ISSUE_EN, ISSUE_RD, FLUSH,
    output RS1_DATA, RS2_DATA, RS1_BUSY, RS2_BUSY, PENDING_CNT
  );

endinterface

// File: rtl/regfile_bypass_sb.sv
// Purpose: parametrised ID-stage register file with hardwired x0, optional
// same-cycle writeback-to-read bypass and a per-register busy scoreboard
// with a registered pending counter for hazard detection.
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RESET  synchronous active-high reset
//   bus    regfile_bypass_sb_if.slave (read, writeback, issue, flush, status)
// Parameters:
//   XLEN        register width
//   NREGS       number of architectural registers (2..2**AW)
//   AW          address width
//   RESET_MODE  0: all registers reset to 0; 1: register i resets to i (x0 = 0)
//   BYPASS      1: writeback data and busy-clear are visible to same-cycle reads
module regfile_bypass_sb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned RESET_MODE = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  regfile_bypass_sb_if.slave  bus
);

  localparam int unsigned CW      = AW + 1;
  localparam logic [AW:0] NREGS_W = CW'(NREGS);

  // Address is architecturally writable/readable: nonzero and in range.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  // Per-register reset value.
  function automatic logic [XLEN-1:0] reset_val(input int unsigned i);
    if ((RESET_MODE == 0) || (i == 0)) begin
      return '0;
    end
    return XLEN'(i);
  endfunction

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      pending_cnt_q;
  logic [AW:0]      pending_cnt_d;

  logic wb_ok;
  logic issue_ok;

  assign wb_ok    = bus.WB_EN    && addr_ok(bus.WB_ADDR);
  assign issue_ok = bus.ISSUE_EN && addr_ok(bus.ISSUE_RD);

  // Next array contents: writeback is independent of flush.
  always_comb begin
    regs_d = regs_q;
    if (wb_ok) begin
      regs_d[bus.WB_ADDR] = bus.WB_DATA;
    end
  end

  // Next busy vector: flush beats issue, issue (new producer) beats writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (bus.FLUSH) begin
      busy_d = '0;
    end else begin
      if (wb_ok) begin
        busy_d[bus.WB_ADDR] = 1'b0;
      end
      if (issue_ok) begin
        busy_d[bus.ISSUE_RD] = 1'b1;
      end
    end
  end

  // Pending count tracks the population of the next busy vector.
  always_comb begin
    pending_cnt_d = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      pending_cnt_d = pending_cnt_d + CW'(busy_d[i]);
    end
  end

  // State registers; reset discards all outstanding scoreboard state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= reset_val(i);
      end
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  // Read port 1: x0/out-of-range read as idle zero; optional forwarding.
  always_comb begin
    bus.RS1_DATA = '0;
    bus.RS1_BUSY = 1'b0;
    if (addr_ok(bus.RS1_ADDR)) begin
      bus.RS1_DATA = regs_q[bus.RS1_ADDR];
      bus.RS1_BUSY = busy_q[bus.RS1_ADDR];
      if ((BYPASS != 0) && bus.WB_EN && (bus.WB_ADDR == bus.RS1_ADDR)) begin
        bus.RS1_DATA = bus.WB_DATA;
        bus.RS1_BUSY = 1'b0;
      end
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    bus.RS2_DATA = '0;
    bus.RS2_BUSY = 1'b0;
    if (addr_ok(bus.RS2_ADDR)) begin
      bus.RS2_DATA = regs_q[bus.RS2_ADDR];
      bus.RS2_BUSY = busy_q[bus.RS2_ADDR];
      if ((BYPASS != 0) && bus.WB_EN && (bus.WB_ADDR == bus.RS2_ADDR)) begin
        bus.RS2_DATA = bus.WB_DATA;
        bus.RS2_BUSY = 1'b0;
      end
    end
  end

  assign bus.PENDING_CNT = pending_cnt_q;

endmodule
